// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
// Optional feature macro: UART_TX_BREAK_EN adds the BREAK state.
package uart_pkg;

    // Transmitter FSM states; BREAK exists only when line-break support is built in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK
`endif
    } uart_state_e;

    // Number of bit periods in one frame: start + payload + optional parity + stops.
    function automatic int frame_bits(input int data_bits, input int has_parity, input int stop_bits);
        return 1 + data_bits + ((has_parity != 0) ? 1 : 0) + stop_bits;
    endfunction

    // Parity bit from the XOR-reduction of the payload: even keeps it, odd inverts it.
    function automatic logic parity_bit(input logic data_xor, input logic even);
        return even ? data_xor : ~data_xor;
    endfunction

    // Clock cycles per line bit, truncating division.
    function automatic int bit_period(input int sys_clk, input int baud_rate);
        return sys_clk / baud_rate;
    endfunction

endpackage

// File: rtl/timer.sv
// Baud-period timer: counts 0..N-1 while enabled and pulses tick for one
// cycle on the last count. Held at 0 while disabled.
module timer #(
    parameter int N = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == CW'(N - 1));

    // Next count: restart on disable or at the end of each period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, 1..3 stop bits.
// Optional feature macro: UART_TX_BREAK_EN adds input send_break, which drives
// the line low for one full frame time instead of sending data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int BAUD_RATE   = 115200,
    parameter int SYS_CLK     = 100_000_000,
    parameter int STOP_BITS   = 1,
    parameter int HAS_PARITY  = 0,
    parameter int PARITY_EVEN = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data_in,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break,
`endif
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int N     = bit_period(SYS_CLK, BAUD_RATE);
    localparam int FRAME = frame_bits(DATA_BITS, HAS_PARITY, STOP_BITS);
    localparam int CW    = $clog2(FRAME + 1);

    uart_state_e          state_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [CW-1:0]        bit_cnt_q;
    logic                 tick;

    assign ready = ready_q;
    assign busy  = busy_q;
    assign tx    = tx_q;

    // The baud counter runs only while a frame or break is on the line.
    timer #(
        .N(N)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    // Frame sequencer; all outputs are registered so tx never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                    bit_cnt_q <= '0;
`ifdef UART_TX_BREAK_EN
                    if (send_break && ready_q) begin
                        state_q <= BREAK;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else
`endif
                    if (valid && ready_q) begin
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        shift_q  <= data_in;
                        parity_q <= parity_bit(^data_in, PARITY_EVEN != 0);
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (HAS_PARITY != 0) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_q   <= STOP;
                        tx_q      <= 1'b1;
                        bit_cnt_q <= '0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == CW'(STOP_BITS - 1)) begin
                            state_q   <= IDLE;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (tick) begin
                        if (bit_cnt_q == CW'(FRAME - 1)) begin
                            state_q   <= IDLE;
                            tx_q      <= 1'b1;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q   <= IDLE;
                    tx_q      <= 1'b1;
                    ready_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    bit_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8: payload bits per frame.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200: line bit rate.
REQ-003 The block SHALL have parameter SYS_CLK, default 100_000_000: clk frequency in Hz.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal range 1..3.
REQ-005 The block SHALL have parameter HAS_PARITY, default 0: 1 appends a parity bit.
REQ-006 The block SHALL have parameter PARITY_EVEN, default 0: 1 selects even parity, 0 selects odd parity.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port valid, input, 1 bit: upstream request; data_in is valid.
REQ-010 The block SHALL have port data_in, input, DATA_BITS bits: byte to send.
REQ-011 The block SHALL have port ready, output, 1 bit: acknowledge; the block can accept data.
REQ-012 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit: a frame or break is in progress.

Function
REQ-014 The bit period SHALL be N = SYS_CLK/BAUD_RATE clk cycles, using integer division.
REQ-015 Frame order SHALL be: start (0); data LSB first; parity if HAS_PARITY; STOP_BITS stop bits (1).
REQ-016 The parity bit SHALL be ^data_in when PARITY_EVEN=1 and ~^data_in when PARITY_EVEN=0.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when HAS_PARITY=0.
REQ-018 ready SHALL be 1 only in IDLE; a transfer SHALL occur on a clk edge where valid && ready.
REQ-019 data_in SHALL be latched at acceptance; later changes to data_in SHALL NOT affect the frame in progress.
REQ-020 tx SHALL go low on the first cycle after acceptance; ready SHALL fall and busy SHALL rise on that same cycle.
REQ-021 Each bit SHALL be held for exactly N cycles.
REQ-022 The total frame SHALL last (1+DATA_BITS+HAS_PARITY+STOP_BITS)*N cycles.
REQ-023 After the last stop bit, the block SHALL enter IDLE: ready=1 and busy=0 on the next cycle.
REQ-024 With valid held high, the next start bit SHALL begin within 1 cycle after the final stop period, adding at most 1 idle cycle.
REQ-025 In IDLE, tx SHALL be 1 and the baud counter SHALL be held at 0.
REQ-026 tx SHALL be registered and glitch-free.

Reset
REQ-027 During reset, tx SHALL be 1, ready 0, busy 0, state IDLE, and all counters 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with tx=1 asynchronously.
REQ-029 ready SHALL rise on the first clk edge after reset deasserts.

Configuration
REQ-030 When macro UART_TX_BREAK_EN is defined, the block SHALL add input port send_break (1 bit).
REQ-031 With UART_TX_BREAK_EN defined, send_break=1 in IDLE SHALL enter state BREAK and hold tx=0 for (1+DATA_BITS+HAS_PARITY+STOP_BITS)*N cycles, with ready=0 and busy=1, then return to IDLE.
REQ-032 With UART_TX_BREAK_EN defined, if send_break and valid are both 1 in IDLE, send_break SHALL take priority and the data SHALL NOT be accepted.
REQ-033 With UART_TX_BREAK_EN undefined, the port and BREAK state SHALL be absent and the behaviour SHALL be identical to REQ-014..029.

Structure
REQ-034 Package uart_pkg SHALL hold the state enum typedef, the parity function, and the frame-length constant computation.
REQ-035 The baud period SHALL come from a single sub-module, timer, instantiated with N and giving a 1-cycle tick.
REQ-036 The block's frames SHALL be decoded correctly by uart_rx for every combination of DATA_BITS, STOP_BITS, HAS_PARITY and PARITY_EVEN.

Verification
REQ-037 Scenario: SYS_CLK=1_000_000, BAUD=100_000 (N=10), send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; frame 100 cycles.
REQ-038 Scenario: HAS_PARITY=1, PARITY_EVEN=0, send 0x03 -> parity bit 1; PARITY_EVEN=1 -> parity bit 0.
REQ-039 Scenario: valid held with 0x11 then 0x22, STOP_BITS=2 -> two frames of 110 cycles each, at most 1 idle cycle between them, ready pulses once per frame.
REQ-040 Scenario: assert reset in the middle of data bit 4 -> tx=1 immediately; after release, ready=1 next edge and a new frame sends correctly.
REQ-041 Scenario: loopback into uart_rx, 256 random bytes -> all received equal, valid/ready handshakes complete.
REQ-042 Scenario: UART_TX_BREAK_EN defined, send_break and valid both 1 -> tx low for 100 cycles, data not accepted, then normal frame.
